// File: rtl/jelly3_jfive_shifter_arbiter.sv
// Round-robin arbiter sharing one pipelined shifter between several issue
// requesters. Per-op tags (port, id, rd_idx) ride a tag pipe alongside the
// shifter. Output back-pressure freezes the whole pipe through a shared enable.

// Pipelined shifter: combinational shift followed by LATENCY enabled registers.
module jelly3_jfive_shifter #(
  parameter int XLEN       = 32,
  parameter int SHAMT_BITS = $clog2(XLEN),
  parameter int LATENCY    = 2,
  parameter     DEVICE     = "RTL",
  parameter     SIMULATION = "false",
  parameter     DEBUG      = "false"
) (
  input  logic                  reset,
  input  logic                  clk,
  input  logic                  cke,
  input  logic                  s_arithmetic,
  input  logic                  s_left,
  input  logic [XLEN-1:0]       s_rs1_val,
  input  logic [SHAMT_BITS-1:0] s_shamt,
  output logic [XLEN-1:0]       m_rd_val
);

  // Non-RTL targets, and debug simulations, use an explicit log-stage shifter so
  // every stage is visible; plain RTL lets synthesis pick the structure.
  localparam bit USE_TREE = (DEVICE != "RTL") || (SIMULATION == "true" && DEBUG == "true");

  logic [XLEN-1:0] shift_val;
  logic [XLEN-1:0] tree_val;
  logic            tree_fill;
  logic [XLEN-1:0] data_reg [LATENCY];

  // Shift result: left, logical right, or arithmetic right (left wins over arithmetic).
  always_comb begin
    tree_val  = s_rs1_val;
    tree_fill = s_arithmetic & ~s_left & s_rs1_val[XLEN-1];
    for (int b = 0; b < SHAMT_BITS; b++) begin
      if (s_shamt[b]) begin
        if (s_left) begin
          tree_val = tree_val << (1 << b);
        end else begin
          tree_val = (tree_val >> (1 << b)) | (tree_fill ? ~({XLEN{1'b1}} >> (1 << b)) : '0);
        end
      end
    end
    if (USE_TREE) begin
      shift_val = tree_val;
    end else if (s_left) begin
      shift_val = s_rs1_val << s_shamt;
    end else if (s_arithmetic) begin
      shift_val = $signed(s_rs1_val) >>> s_shamt;
    end else begin
      shift_val = s_rs1_val >> s_shamt;
    end
  end

  // Result delay line; moves only on enabled cycles so stalls hold every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        data_reg[i] <= '0;
      end
    end else if (cke) begin
      data_reg[0] <= shift_val;
      for (int i = 1; i < LATENCY; i++) begin
        data_reg[i] <= data_reg[i-1];
      end
    end
  end

  assign m_rd_val = data_reg[LATENCY-1];

endmodule

module jelly3_jfive_shifter_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int PORT_BITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int XLEN       = 32,
  parameter int SHAMT_BITS = $clog2(XLEN),
  parameter int ID_BITS    = 4,
  parameter int RIDX_BITS  = 6,
  parameter int LATENCY    = 2,
  parameter     DEVICE     = "RTL",
  parameter     SIMULATION = "false",
  parameter     DEBUG      = "false"
) (
  input  logic                            reset,
  input  logic                            clk,
  input  logic                            cke,
  input  logic [NUM_PORTS-1:0]            s_valid,
  output logic [NUM_PORTS-1:0]            s_ready,
  input  logic [NUM_PORTS-1:0]            s_arithmetic,
  input  logic [NUM_PORTS-1:0]            s_left,
  input  logic [NUM_PORTS-1:0]            s_imm_en,
  input  logic [NUM_PORTS*XLEN-1:0]       s_rs1_val,
  input  logic [NUM_PORTS*SHAMT_BITS-1:0] s_rs2_val,
  input  logic [NUM_PORTS*SHAMT_BITS-1:0] s_shamt,
  input  logic [NUM_PORTS*RIDX_BITS-1:0]  s_rd_idx,
  input  logic [NUM_PORTS*ID_BITS-1:0]    s_id,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [PORT_BITS-1:0]            m_port,
  output logic [ID_BITS-1:0]              m_id,
  output logic [RIDX_BITS-1:0]            m_rd_idx,
  output logic [XLEN-1:0]                 m_rd_val
);

  logic                  stall;
  logic                  advance;
  logic [PORT_BITS-1:0]  rr_reg;
  logic                  grant_found;
  logic [PORT_BITS-1:0]  grant_idx;
  logic [PORT_BITS-1:0]  cand;
  logic                  handshake;

  logic [XLEN-1:0]       rs1_arr   [NUM_PORTS];
  logic [SHAMT_BITS-1:0] rs2_arr   [NUM_PORTS];
  logic [SHAMT_BITS-1:0] shamt_arr [NUM_PORTS];
  logic [RIDX_BITS-1:0]  ridx_arr  [NUM_PORTS];
  logic [ID_BITS-1:0]    id_arr    [NUM_PORTS];

  logic                  sel_arith;
  logic                  sel_left;
  logic [XLEN-1:0]       sel_rs1;
  logic [SHAMT_BITS-1:0] sel_amt;

  logic                  tag_valid_reg [LATENCY];
  logic [PORT_BITS-1:0]  tag_port_reg  [LATENCY];
  logic [ID_BITS-1:0]    tag_id_reg    [LATENCY];
  logic [RIDX_BITS-1:0]  tag_ridx_reg  [LATENCY];

  // Unpack the flat per-port payload buses.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign rs1_arr[gi]   = s_rs1_val[gi*XLEN +: XLEN];
    assign rs2_arr[gi]   = s_rs2_val[gi*SHAMT_BITS +: SHAMT_BITS];
    assign shamt_arr[gi] = s_shamt[gi*SHAMT_BITS +: SHAMT_BITS];
    assign ridx_arr[gi]  = s_rd_idx[gi*RIDX_BITS +: RIDX_BITS];
    assign id_arr[gi]    = s_id[gi*ID_BITS +: ID_BITS];
  end

  // A pending result nobody takes freezes everything upstream; reset also blocks grants.
  assign stall   = m_valid & ~m_ready;
  assign advance = cke & ~stall & ~reset;

  // Round-robin search: first valid port at or after the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PORT_BITS'((int'(rr_reg) + k) % NUM_PORTS);
      if (!grant_found && s_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign handshake = advance & grant_found;
  assign s_ready   = handshake ? (NUM_PORTS'(1) << grant_idx) : '0;

  // Payload of the granted port feeds the shifter; don't-care on bubbles.
  assign sel_arith = s_arithmetic[grant_idx];
  assign sel_left  = s_left[grant_idx];
  assign sel_rs1   = rs1_arr[grant_idx];
  assign sel_amt   = s_imm_en[grant_idx] ? shamt_arr[grant_idx] : rs2_arr[grant_idx];

  // Pointer moves just past the port that completed a handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_reg <= '0;
    end else if (handshake) begin
      rr_reg <= (grant_idx == PORT_BITS'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tag pipe runs in lockstep with the shifter so tags line up with results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_valid_reg[i] <= 1'b0;
        tag_port_reg[i]  <= '0;
        tag_id_reg[i]    <= '0;
        tag_ridx_reg[i]  <= '0;
      end
    end else if (advance) begin
      tag_valid_reg[0] <= grant_found;
      tag_port_reg[0]  <= grant_found ? grant_idx : '0;
      tag_id_reg[0]    <= grant_found ? id_arr[grant_idx] : '0;
      tag_ridx_reg[0]  <= grant_found ? ridx_arr[grant_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_port_reg[i]  <= tag_port_reg[i-1];
        tag_id_reg[i]    <= tag_id_reg[i-1];
        tag_ridx_reg[i]  <= tag_ridx_reg[i-1];
      end
    end
  end

  assign m_valid  = tag_valid_reg[LATENCY-1];
  assign m_port   = tag_port_reg[LATENCY-1];
  assign m_id     = tag_id_reg[LATENCY-1];
  assign m_rd_idx = tag_ridx_reg[LATENCY-1];

  jelly3_jfive_shifter #(
    .XLEN       (XLEN),
    .SHAMT_BITS (SHAMT_BITS),
    .LATENCY    (LATENCY),
    .DEVICE     (DEVICE),
    .SIMULATION (SIMULATION),
    .DEBUG      (DEBUG)
  ) u_shifter (
    .reset        (reset),
    .clk          (clk),
    .cke          (advance),
    .s_arithmetic (sel_arith),
    .s_left       (sel_left),
    .s_rs1_val    (sel_rs1),
    .s_shamt      (sel_amt),
    .m_rd_val     (m_rd_val)
  );

endmodule

// File: tb/tb_jelly3_jfive_shifter_arbiter.sv
// Directed vectors plus multi-cycle sequences (alternation, stall, reset,
// random cke/back-pressure) against a scoreboard for the shifter arbiter.
module tb_jelly3_jfive_shifter_arbiter;

  localparam int NP   = 2;
  localparam int XLEN = 32;
  localparam int SB   = 5;
  localparam int IDB  = 4;
  localparam int RB   = 6;
  localparam int LAT  = 2;
  localparam int NOPS = 1000;

  logic              reset;
  logic              clk;
  logic              cke;
  logic [NP-1:0]     s_valid;
  logic [NP-1:0]     s_ready;
  logic [NP-1:0]     s_arithmetic;
  logic [NP-1:0]     s_left;
  logic [NP-1:0]     s_imm_en;
  logic [NP*XLEN-1:0] s_rs1_val;
  logic [NP*SB-1:0]  s_rs2_val;
  logic [NP*SB-1:0]  s_shamt;
  logic [NP*RB-1:0]  s_rd_idx;
  logic [NP*IDB-1:0] s_id;
  logic              m_valid;
  logic              m_ready;
  logic [0:0]        m_port;
  logic [IDB-1:0]    m_id;
  logic [RB-1:0]     m_rd_idx;
  logic [XLEN-1:0]   m_rd_val;

  jelly3_jfive_shifter_arbiter #(
    .NUM_PORTS (NP), .XLEN (XLEN), .ID_BITS (IDB), .RIDX_BITS (RB), .LATENCY (LAT)
  ) dut (
    .reset (reset), .clk (clk), .cke (cke),
    .s_valid (s_valid), .s_ready (s_ready), .s_arithmetic (s_arithmetic),
    .s_left (s_left), .s_imm_en (s_imm_en), .s_rs1_val (s_rs1_val),
    .s_rs2_val (s_rs2_val), .s_shamt (s_shamt), .s_rd_idx (s_rd_idx), .s_id (s_id),
    .m_valid (m_valid), .m_ready (m_ready), .m_port (m_port), .m_id (m_id),
    .m_rd_idx (m_rd_idx), .m_rd_val (m_rd_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [IDB-1:0] id;
    logic [RB-1:0]  ridx;
    logic [31:0]    val;
  } exp_t;

  typedef struct {
    int          port;
    bit          a;
    bit          l;
    bit          i;
    logic [31:0] rs1;
    logic [4:0]  rs2;
    logic [4:0]  sh;
    logic [5:0]  ridx;
    logic [3:0]  id;
    logic [31:0] expv;
  } vec_t;

  exp_t    exp_q[$];
  int      grant_log[$];
  int      tests = 0;
  int      errors = 0;
  int      n_out = 0;
  int      issued[NP];
  logic [NP-1:0] hs_mask;
  bit      sb_en = 0;
  vec_t    vecs[10];

  function automatic logic [31:0] model(bit a, bit l, bit imm, logic [31:0] rs1,
                                        logic [4:0] rs2, logic [4:0] sh);
    logic [4:0] amt;
    amt = imm ? sh : rs2;
    if (l) return rs1 << amt;
    if (a) return $signed(rs1) >>> amt;
    return rs1 >> amt;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic set_port(input int p, input bit a, input bit l, input bit imm,
                          input logic [31:0] rs1, input logic [4:0] rs2, input logic [4:0] sh,
                          input logic [5:0] ridx, input logic [3:0] id);
    s_arithmetic[p]         = a;
    s_left[p]               = l;
    s_imm_en[p]             = imm;
    s_rs1_val[p*XLEN +: XLEN] = rs1;
    s_rs2_val[p*SB +: SB]   = rs2;
    s_shamt[p*SB +: SB]     = sh;
    s_rd_idx[p*RB +: RB]    = ridx;
    s_id[p*IDB +: IDB]      = id;
  endtask

  task automatic new_req(input int p);
    set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom, 5'($urandom), 5'($urandom), 6'($urandom), 4'($urandom));
    s_valid[p] = 1'b1;
    issued[p]++;
  endtask

  // Advance one edge, then retire any request the DUT accepted on that edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) if (hs_mask[p]) s_valid[p] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || s_valid != '0) && n < 200) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: handshakes push model results, consumed outputs are checked in order.
  always @(negedge clk) begin : monitor
    exp_t e;
    hs_mask = '0;
    if (!reset) begin
      if (sb_en && cke && m_valid && m_ready) begin
        n_out++;
        tests++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got port=%0d val=%h, expected no result", m_port, m_rd_val);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] result port=%0d id=%h rd=%0d val=%h", m_port, m_id, m_rd_idx, m_rd_val);
          if (int'(m_port) != e.port || m_id !== e.id || m_rd_idx !== e.ridx || m_rd_val !== e.val) begin
            errors++;
            $display("FAIL sb_result: got port=%0d id=%h rd=%0d val=%h, expected port=%0d id=%h rd=%0d val=%h",
                     m_port, m_id, m_rd_idx, m_rd_val, e.port, e.id, e.ridx, e.val);
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (s_valid[p] && s_ready[p]) begin
          hs_mask[p] = 1'b1;
          if (sb_en) begin
            e.port = p;
            e.id   = s_id[p*IDB +: IDB];
            e.ridx = s_rd_idx[p*RB +: RB];
            e.val  = model(s_arithmetic[p], s_left[p], s_imm_en[p], s_rs1_val[p*XLEN +: XLEN],
                           s_rs2_val[p*SB +: SB], s_shamt[p*SB +: SB]);
            exp_q.push_back(e);
            grant_log.push_back(p);
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    int n0;
    // port, arith, left, imm, rs1, rs2, shamt, rd, id, expected
    vecs[0] = '{0, 0, 0, 0, 32'h8000_0000, 5'd4,  5'd0,  6'd1,  4'h3, 32'h0800_0000};
    vecs[1] = '{0, 1, 0, 0, 32'h8000_0000, 5'd4,  5'd0,  6'd2,  4'h5, 32'hF800_0000};
    vecs[2] = '{0, 0, 1, 1, 32'h0000_0001, 5'd5,  5'd31, 6'd3,  4'h7, 32'h8000_0000};
    vecs[3] = '{1, 1, 1, 1, 32'h0000_00F1, 5'd0,  5'd4,  6'd4,  4'h9, 32'h0000_0F10};
    vecs[4] = '{1, 1, 0, 1, 32'h8000_0001, 5'd9,  5'd0,  6'd5,  4'hA, 32'h8000_0001};
    vecs[5] = '{1, 1, 0, 0, 32'h8000_0000, 5'd31, 5'd2,  6'd6,  4'hB, 32'hFFFF_FFFF};
    vecs[6] = '{0, 0, 0, 1, 32'hFFFF_FFFF, 5'd0,  5'd31, 6'd7,  4'hC, 32'h0000_0001};
    vecs[7] = '{1, 0, 1, 0, 32'h1234_5678, 5'd8,  5'd1,  6'd63, 4'hD, 32'h3456_7800};
    vecs[8] = '{0, 1, 0, 0, 32'h7000_0000, 5'd4,  5'd0,  6'd8,  4'hE, 32'h0700_0000};
    vecs[9] = '{1, 0, 0, 0, 32'hABCD_1234, 5'd16, 5'd3,  6'd9,  4'hF, 32'h0000_ABCD};

    reset = 1'b1; cke = 1'b1; m_ready = 1'b1;
    s_valid = '1; s_arithmetic = '0; s_left = '0; s_imm_en = '0;
    s_rs1_val = '0; s_rs2_val = '0; s_shamt = '0; s_rd_idx = '0; s_id = '0;
    for (int p = 0; p < NP; p++) issued[p] = 0;

    // Reset state, with requests already waiting.
    @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_port", 64'(m_port), 64'd0);
    chk("rst_m_id", 64'(m_id), 64'd0);
    chk("rst_m_rd_idx", 64'(m_rd_idx), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    s_valid = '0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed single-op vectors: grant, exact latency, result fields.
    for (int v = 0; v < 10; v++) begin
      set_port(vecs[v].port, vecs[v].a, vecs[v].l, vecs[v].i, vecs[v].rs1,
               vecs[v].rs2, vecs[v].sh, vecs[v].ridx, vecs[v].id);
      s_valid[vecs[v].port] = 1'b1;
      @(negedge clk);
      chk("vec_s_ready", 64'(s_ready), 64'(1 << vecs[v].port));
      step();
      @(negedge clk);
      chk("vec_latency_early", 64'(m_valid), 64'd0);
      step();
      @(negedge clk);
      chk("vec_m_valid", 64'(m_valid), 64'd1);
      chk("vec_m_port", 64'(m_port), 64'(vecs[v].port));
      chk("vec_m_id", 64'(m_id), 64'(vecs[v].id));
      chk("vec_m_rd_idx", 64'(m_rd_idx), 64'(vecs[v].ridx));
      chk("vec_m_rd_val", 64'(m_rd_val), 64'(vecs[v].expv));
      $display("[TB] vec %0d port=%0d val=%h", v, m_port, m_rd_val);
      step();
    end

    // Both ports always valid: strict alternation, one result per cycle.
    sb_en = 1;
    grant_log.delete();
    new_req(0);
    new_req(1);
    for (int i = 0; i < 8; i++) begin
      step();
      for (int p = 0; p < NP; p++) if (!s_valid[p]) new_req(p);
      @(negedge clk);
      if (i >= 1) chk("alt_m_valid", 64'(m_valid), 64'd1);
    end
    s_valid = '0;
    drain();
    for (int i = 0; i < 8; i++)
      chk("alt_grant", (i < grant_log.size()) ? 64'(grant_log[i]) : 64'hFFFF, 64'(i % 2));

    // Back-pressure with two ops in flight and a third request waiting.
    m_ready = 1'b0;
    n0 = n_out;
    new_req(0);
    step();
    new_req(1);
    step();
    new_req(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_m_valid", 64'(m_valid), 64'd1);
      chk("stall_m_port", 64'(m_port), 64'd0);
      chk("stall_m_rd_val", 64'(m_rd_val), (exp_q.size() > 0) ? 64'(exp_q[0].val) : 64'hDEAD);
      chk("stall_s_ready", 64'(s_ready), 64'd0);
      step();
    end
    m_ready = 1'b1;
    drain();
    chk("stall_delivered", 64'(n_out - n0), 64'd3);

    // Reset with ops in flight, pointer sitting at port 1.
    new_req(1);
    step();
    new_req(0);
    step();
    reset = 1'b1;
    #1;
    chk("rst_flight_m_valid", 64'(m_valid), 64'd0);
    exp_q.delete();
    s_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(m_valid), 64'd0);
      step();
    end
    new_req(0);
    new_req(1);
    @(negedge clk);
    chk("rst_rr_zero", 64'(s_ready), 64'b01);
    step();
    drain();

    // Random cke and back-pressure against the scoreboard.
    for (int p = 0; p < NP; p++) issued[p] = 0;
    cyc = 0;
    while ((issued[0] < NOPS || issued[1] < NOPS || s_valid != '0) && cyc < 40000) begin
      step();
      cke     = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++)
        if (!s_valid[p] && issued[p] < NOPS && $urandom_range(0, 1) == 1) new_req(p);
      cyc++;
    end
    chk("rand_bound", 64'(cyc < 40000), 64'd1);
    cke = 1'b1;
    m_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
